// File: rtl/demux_serial_dispatch_if.sv
// -----------------------------------------------------------------------------
// demux_serial_dispatch_if
//
// Purpose : groups the upstream valid/ready word interface and the serial
//           demux-facing outputs of demux_serial_dispatch into one bundle.
//
// Signals :
//   in_valid  upstream -> block  word and channel are presented
//   in_ready  block -> upstream  block can accept (IDLE and out of reset)
//   in_data   upstream -> block  payload word, DATA_W bits
//   in_chan   upstream -> block  destination demux channel, 0..3
//   a         block -> demux     serial data, LSB first
//   s         block -> demux     channel select, stable for a whole frame
//   busy      block -> observer  high whenever a frame is in progress
//   done      block -> observer  one-cycle pulse on the last bit of a frame
//   frame_cnt block -> observer  completed-frame counter, wraps at 256
//
// Modports:
//   master  the upstream feeder / testbench side
//   slave   the demux_serial_dispatch side
// -----------------------------------------------------------------------------
interface demux_serial_dispatch_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_chan;
  logic              a;
  logic [1:0]        s;
  logic              busy;
  logic              done;
  logic [7:0]        frame_cnt;

  modport master (
    output in_valid, in_data, in_chan,
    input  in_ready, a, s, busy, done, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, in_chan,
    output in_ready, a, s, busy, done, frame_cnt
  );
endinterface

// File: rtl/demux_serial_dispatch.sv
// -----------------------------------------------------------------------------
// demux_serial_dispatch
//
// Purpose : upstream feeder for a 1-to-4 demultiplexer. Takes a parallel word
//           and a 2-bit channel over valid/ready, shifts the word out LSB
//           first on `a` while holding `s` at the captured channel, then
//           idles one GAP cycle with `a` low before accepting the next word.
//           Signals frame completion with `done` and counts frames.
//
// Parameters:
//   DATA_W   payload width, 2..32 (default 8); must match the interface.
//
// Ports:
//   clk      single clock, rising edge
//   rst_n    synchronous active-low reset
//   bus      demux_serial_dispatch_if.slave (see the interface header)
//
// Build option:
//   DEMUX_DISPATCH_PARITY_EN  when defined, an even-parity bit (XOR of the
//                             payload) follows the data bits in a PAR cycle,
//                             and `done` moves onto that parity cycle.
//                             Frame period becomes DATA_W+3 instead of
//                             DATA_W+2.
//
// Frame timing (accept edge E0):
//   cycle E0+1+k : payload bit k on `a`, channel on `s`
//   [parity]     : E0+1+DATA_W when compiled in
//   GAP          : cycle after the last bit, `a`=0
//   IDLE         : in_ready high again
// -----------------------------------------------------------------------------
module demux_serial_dispatch #(
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  demux_serial_dispatch_if.slave  bus
);

  // Wide enough to hold the count DATA_W itself.
  localparam int IDX_W = $clog2(DATA_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef DEMUX_DISPATCH_PARITY_EN
  localparam logic [1:0] ST_PAR   = 2'd2;
`endif
  localparam logic [1:0] ST_GAP   = 2'd3;

  // r_idx counts bits already placed on `a`, including the one showing now.
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX_M1 = IDX_W'(DATA_W - 1);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic              r_a;
  logic [1:0]        r_s;
  logic              r_done;
  logic [7:0]        r_frame_cnt;
`ifdef DEMUX_DISPATCH_PARITY_EN
  logic              r_parity;
`endif

  logic              w_accept;

  // in_ready is gated by rst_n so a request on a reset edge is never taken.
  assign bus.in_ready  = (r_state == ST_IDLE) && rst_n;
  assign w_accept      = bus.in_valid && bus.in_ready;

  assign bus.a         = r_a;
  assign bus.s         = r_s;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.frame_cnt = r_frame_cnt;

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours; blocking
  // assignments here would make e.g. r_a see the already-shifted r_shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      // NOTE: the shift register is a plain datapath register, not a memory
      // array, so clearing it costs nothing and keeps the post-reset state
      // fully defined.
      r_shift     <= '0;
      r_idx       <= '0;
      r_a         <= 1'b0;
      r_s         <= 2'd0;
      r_done      <= 1'b0;
      r_frame_cnt <= 8'd0;
`ifdef DEMUX_DISPATCH_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      // The counter steps at the edge that closes the cycle `done` was high.
      if (r_done) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end

      case (r_state)
        ST_IDLE: begin
          r_a    <= 1'b0;
          r_done <= 1'b0;
          if (w_accept) begin
            // Bit 0 goes straight onto `a` so it shows in cycle E0+1; the
            // register keeps the remaining bits.
            r_a     <= bus.in_data[0];
            r_shift <= bus.in_data >> 1;
            r_s     <= bus.in_chan;
            r_idx   <= IDX_W'(1);
`ifdef DEMUX_DISPATCH_PARITY_EN
            r_parity <= ^bus.in_data;
`endif
            r_state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (r_idx != LAST_IDX) begin
            r_a     <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_idx   <= r_idx + 1'b1;
`ifdef DEMUX_DISPATCH_PARITY_EN
            r_done  <= 1'b0;
`else
            // The bit being loaded now is the last one of the frame.
            r_done  <= (r_idx == LAST_IDX_M1);
`endif
          end else begin
            // The last payload bit is on `a` during this cycle.
`ifdef DEMUX_DISPATCH_PARITY_EN
            r_a     <= r_parity;
            r_done  <= 1'b1;
            r_state <= ST_PAR;
`else
            r_a     <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_GAP;
`endif
          end
        end

`ifdef DEMUX_DISPATCH_PARITY_EN
        ST_PAR: begin
          r_a     <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_GAP;
        end
`endif

        ST_GAP: begin
          r_a     <= 1'b0;
          r_done  <= 1'b0;
          r_idx   <= '0;
          r_state <= ST_IDLE;
        end

        default: begin
          // Unused encoding: fall back to a quiet IDLE.
          r_a     <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_serial_dispatch.sv
// -----------------------------------------------------------------------------
// tb_demux_serial_dispatch
//
// Self-checking bench for demux_serial_dispatch (DATA_W = 8). Works in both
// builds: parity expectations follow DEMUX_DISPATCH_PARITY_EN.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_demux_serial_dispatch;

  localparam int DATA_W = 8;
`ifdef DEMUX_DISPATCH_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [1:0] chan;
    logic       par;        // hand-computed even parity of data
    logic [7:0] post_data;  // driven right after the accept edge
    logic [1:0] post_chan;
    logic       post_valid;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  demux_serial_dispatch_if #(.DATA_W(DATA_W)) bus ();

  demux_serial_dispatch #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] model_cnt;
  int         done_cnt;
  vec_t       vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full frame with every output checked cycle by cycle.
  task automatic run_frame(input vec_t v, input int idx);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v.data;
    bus.in_chan  = v.chan;
    #1;
    while (!bus.in_ready && waited < 40) begin
      tick();
      waited++;
    end
    check($sformatf("v%0d accept", idx), {31'd0, bus.in_ready}, 32'd1);
    if (bus.in_ready) begin
      tick();  // accept edge E0
      bus.in_valid = v.post_valid;
      bus.in_data  = v.post_data;
      bus.in_chan  = v.post_chan;
      for (int k = 0; k < DATA_W; k++) begin
        check($sformatf("v%0d bit%0d a", idx, k), {31'd0, bus.a}, {31'd0, v.data[k]});
        check($sformatf("v%0d bit%0d s", idx, k), {30'd0, bus.s}, {30'd0, v.chan});
        check($sformatf("v%0d bit%0d done", idx, k), {31'd0, bus.done},
              (k == DATA_W - 1) ? {31'd0, !PAR_EN} : 32'd0);
        if (k == 0) begin
          check($sformatf("v%0d busy", idx), {31'd0, bus.busy}, 32'd1);
          check($sformatf("v%0d in_ready low", idx), {31'd0, bus.in_ready}, 32'd0);
        end
        tick();
      end
`ifdef DEMUX_DISPATCH_PARITY_EN
      check($sformatf("v%0d par a", idx), {31'd0, bus.a}, {31'd0, v.par});
      check($sformatf("v%0d par done", idx), {31'd0, bus.done}, 32'd1);
      check($sformatf("v%0d par s", idx), {30'd0, bus.s}, {30'd0, v.chan});
      tick();
`endif
      model_cnt = model_cnt + 8'd1;
      // GAP cycle
      check($sformatf("v%0d gap a", idx), {31'd0, bus.a}, 32'd0);
      check($sformatf("v%0d gap done", idx), {31'd0, bus.done}, 32'd0);
      check($sformatf("v%0d gap s", idx), {30'd0, bus.s}, {30'd0, v.chan});
      check($sformatf("v%0d gap busy", idx), {31'd0, bus.busy}, 32'd1);
      check($sformatf("v%0d frame_cnt", idx), {24'd0, bus.frame_cnt}, {24'd0, model_cnt});
      tick();
      // IDLE cycle: select still holds the old channel
      check($sformatf("v%0d idle in_ready", idx), {31'd0, bus.in_ready}, 32'd1);
      check($sformatf("v%0d idle busy", idx), {31'd0, bus.busy}, 32'd0);
      check($sformatf("v%0d idle a", idx), {31'd0, bus.a}, 32'd0);
      check($sformatf("v%0d idle s", idx), {30'd0, bus.s}, {30'd0, v.chan});
    end
  endtask

  // Lightweight frame for the wrap test: only counts done pulses.
  task automatic quick_frame(input int f);
    int waited;
    int cyc;
    waited = 0;
    cyc    = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = f[7:0];
    bus.in_chan  = f[1:0];
    #1;
    while (!bus.in_ready && waited < 40) begin
      tick();
      waited++;
    end
    tick();
    bus.in_valid = 1'b0;
    do begin
      if (bus.done) done_cnt++;
      tick();
      cyc++;
    end while (!bus.in_ready && cyc < 40);
    check($sformatf("wrap f%0d in time", f), {31'd0, (cyc < 40)}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 2'd2, 1'b0, 8'h01, 2'd3, 1'b1};
    vecs[1] = '{8'h01, 2'd3, 1'b1, 8'hFE, 2'd1, 1'b0};
    vecs[2] = '{8'hFF, 2'd0, 1'b0, 8'h00, 2'd2, 1'b0};
    vecs[3] = '{8'h80, 2'd1, 1'b1, 8'h7F, 2'd0, 1'b0};
    vecs[4] = '{8'h3C, 2'd3, 1'b0, 8'hC3, 2'd2, 1'b0};
    vecs[5] = '{8'h00, 2'd2, 1'b0, 8'hFF, 2'd1, 1'b0};

    model_cnt = 8'd0;
    done_cnt  = 0;

    // Reset with a request pending: nothing is accepted.
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    bus.in_chan  = 2'd2;
    repeat (3) begin
      tick();
      check("rst a", {31'd0, bus.a}, 32'd0);
      check("rst s", {30'd0, bus.s}, 32'd0);
      check("rst in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
      check("rst busy", {31'd0, bus.busy}, 32'd0);
      check("rst done", {31'd0, bus.done}, 32'd0);
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    tick();
    check("post-rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post-rst busy", {31'd0, bus.busy}, 32'd0);

    // Reset during bit 4 aborts the frame.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    bus.in_chan  = 2'd1;
    tick();               // accept edge E0
    bus.in_valid = 1'b0;
    repeat (4) tick();    // now in cycle E0+5 = bit 4
    check("abort bit4 a", {31'd0, bus.a}, 32'd1);
    check("abort bit4 s", {30'd0, bus.s}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("abort a", {31'd0, bus.a}, 32'd0);
    check("abort s", {30'd0, bus.s}, 32'd0);
    check("abort done", {31'd0, bus.done}, 32'd0);
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check("abort quiet done", {31'd0, bus.done}, 32'd0);
      check("abort quiet a", {31'd0, bus.a}, 32'd0);
    end
    check("abort frame_cnt after", {24'd0, bus.frame_cnt}, 32'd0);

    // Table-driven frames: held input, mid-frame changes, mixed patterns.
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], i);
    end
    bus.in_valid = 1'b0;
    tick();

    // Counter wrap over 256 frames from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("wrap start cnt", {24'd0, bus.frame_cnt}, 32'd0);
    done_cnt = 0;
    for (int f = 1; f <= 256; f++) begin
      quick_frame(f);
      if (f == 255) check("wrap cnt 255", {24'd0, bus.frame_cnt}, 32'd255);
      if (f == 256) check("wrap cnt 0", {24'd0, bus.frame_cnt}, 32'd0);
    end
    check("wrap done pulses", done_cnt, 32'd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/demux_serial_dispatch.md
# demux_serial_dispatch

Upstream feeder for the 1-to-4 demultiplexer. Accepts a parallel word plus a 2-bit destination channel over a valid/ready handshake. Serialises the word LSB-first onto the demux data input `a` while holding the demux select `s` stable for the whole frame. Reports frame completion and keeps a running frame count.

## Interface

- `DATA_W`, default 8: payload width in bits; legal range 2..32.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid` input 1: upstream holds a word and channel.
- `in_ready` output 1: block can accept. Combinational: `state==IDLE && rst_n`.
- `in_data` input DATA_W: payload word.
- `in_chan` input 2: destination demux channel, 0..3.
- `a` output 1: serial data to the demux `a` input. Registered.
- `s` output 2: select to the demux `s` input. Registered.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse coincident with the last serial bit of a frame.
- `frame_cnt` output 8: completed-frame counter; wraps from 255 to 0.

## Operation

- **States:** IDLE, SHIFT, PAR (only when the parity feature is compiled in), GAP.
- **Reset** (rst_n low at an edge):
  - state=IDLE; `a`=0, `s`=0, `done`=0, `frame_cnt`=0; bit index=0; shift register cleared.
  - Reset mid-frame aborts the frame immediately: no `done`, no count increment.
- **IDLE:**
  - `a`=0; `s` holds the last channel used.
  - On `in_valid && in_ready`: capture `in_data` into the shift register and `in_chan` into the select register; go to SHIFT.
- **SHIFT:**
  - Each cycle `a` = current bit, LSB first; `s` = captured channel.
  - Runs exactly DATA_W cycles.
  - On the final bit: go to PAR if enabled, otherwise to GAP.
- **PAR:** one cycle; `a` = even-parity bit (XOR of all DATA_W payload bits); `s` unchanged.
- **GAP:** one cycle; `a`=0, `s` unchanged; then go to IDLE.
- **done / frame_cnt:**
  - `done` is high during the cycle carrying the last bit on `a`: the last data bit, or the parity bit when PAR is enabled.
  - `frame_cnt` increments at the edge ending that cycle.
- **Input changes during a frame:** `in_data` and `in_chan` changes while busy are ignored; captured values are used throughout.
- **Out-of-frame `a`:** `a` is never high outside SHIFT or PAR. The demux therefore sees 0 on all outputs between frames.

## Timing

- **Accept edge E0:** `in_valid` and `in_ready` both high.
  - Bit 0 appears on `a` and the channel on `s` in cycle E0+1.
  - Bit k appears in cycle E0+1+k.
- **Parity:** when enabled, appears in cycle E0+1+DATA_W.
- **GAP:** occupies the cycle after the last bit.
- **Next accept:** `in_ready` returns high the cycle after GAP.
- **Frame period:** DATA_W+2 cycles (DATA_W+3 with parity); no back-to-back streaming.
- **Select stability:** `s` changes only at the E0+1 edge, so it is glitch-free for the demux across the frame.
- **in_ready in reset:** `in_ready` is low while `rst_n` is low. A request presented on the same edge as reset is dropped.
- **Wrap:** `frame_cnt` at 255 wraps to 0 when the next frame completes.

## Configuration

- Macro: `DEMUX_DISPATCH_PARITY_EN`.
- **Defined:**
  - PAR state present; even-parity bit sent after the payload.
  - `done` moves to the parity cycle; frame period is DATA_W+3.
- **Undefined:**
  - PAR state and parity logic absent; `done` is on the last payload bit; frame period is DATA_W+2.
  - All other behaviour identical.

## Test plan

1. **Reset values:** hold `rst_n` low 3 cycles with `in_valid`=1 → `a`=0, `s`=0, `in_ready`=0, `frame_cnt`=0. Release reset → `in_ready`=1 next cycle.
2. **Basic frame:** DATA_W=8, `in_data`=8'hA5, `in_chan`=2 accepted at E0 →
   - `a` = 1,0,1,0,0,1,0,1 in cycles E0+1..E0+8, `s`=2 throughout.
   - `done` high at E0+8 without parity; with parity, PAR bit 0 at E0+9 and `done` there.
   - `frame_cnt`=1 afterwards.
3. **Held input:** `in_valid` held high with a second word 8'h01, chan 3 →
   - Accepted only once `in_ready` returns.
   - `s` switches 2→3 exactly at the first bit cycle of the new frame.
   - Parity bit=1 when enabled.
4. **Mid-frame changes:** change `in_data`/`in_chan` during SHIFT → serial output and `s` unaffected.
5. **Reset mid-frame:** assert `rst_n` low during bit 4 → next cycle `a`=0, `s`=0, no `done`, `frame_cnt` unchanged.
6. **Counter wrap:** send 256 frames → `frame_cnt` reads 255 after frame 255, then 0 after frame 256; exactly 256 `done` pulses.
